// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for the timing generator, drawer and bench.
// Latency: none. This file holds only constants and a helper function.
// Backpressure: none. The raster is free-running.
package vga_timing_pkg;

   localparam int COORD_W  = 10;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   // 0 means negative-polarity syncs, which is what 640x480 monitors expect
   localparam logic SYNC_ACTIVE = 1'b0;

   // Drive the sync line to its active level inside the pulse and to the idle level outside it
   function automatic logic sync_level(input logic in_pulse, input logic active_lvl);
      return in_pulse ? active_lvl : ~active_lvl;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the pattern drawer.
// Latency: none. This file holds wiring only.
// Backpressure: none. The consumer must accept every pixel clock.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic [COORD_W-1:0] xpos;
   logic [COORD_W-1:0] ypos;
   logic               draw_area;
   logic               hsync;
   logic               vsync;
   logic               line_start;
   logic               frame_start;

   modport master (
      output xpos, ypos, draw_area, hsync, vsync, line_start, frame_start
   );

   modport slave (
      input  xpos, ypos, draw_area, hsync, vsync, line_start, frame_start
   );

endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-(TC+1) counter that steps on inc and flags the step that wraps it to zero.
// Latency: value is registered; wrap is combinational from value and inc.
// Backpressure: none. The counter advances whenever inc is high.
module wrap_counter #(
   parameter int W  = 10,
   parameter int TC = 799
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         wrap
);

   localparam logic [W-1:0] TC_V = W'(TC);

   // wrap marks the step that takes value from TC back to zero
   assign wrap = inc && (value == TC_V);

   // Reset parks the counter on its terminal count, so the first enabled step lands on 0
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= TC_V;
      end else if (wrap) begin
         value <= '0;
      end else if (inc) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: 640x480@60 coordinates, draw_area, hsync/vsync, and line/frame pulses.
// Latency: all outputs are registered and describe the same (xpos, ypos). Optional macro VGA_TIMING_SYNC_DELAY_EN adds 2 cycles to the syncs only.
// Backpressure: none. The raster free-runs and is held in its blanking state while rst is high or pll_lock is low.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
   parameter int   H_FP        = vga_timing_pkg::H_FP,
   parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int   H_BP        = vga_timing_pkg::H_BP,
   parameter int   V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
   parameter int   V_FP        = vga_timing_pkg::V_FP,
   parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int   V_BP        = vga_timing_pkg::V_BP,
   parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pll_lock,
   vga_timing_gen_if.master        vid
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_W-1:0] H_ACT_C   = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_C   = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_BEG_C  = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END_C  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_BEG_C  = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END_C  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W)) begin : g_total_too_big
      $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the coordinate range");
   end

   // An unlocked PLL is treated exactly like rst so the drawer never sees a half-built raster
   logic cnt_rst;
   assign cnt_rst = rst | ~pll_lock;

   logic [COORD_W-1:0] x_cur;
   logic [COORD_W-1:0] y_cur;
   logic               h_wrap;
   logic               v_wrap;

   wrap_counter #(.W(COORD_W), .TC(H_TOT - 1)) u_hcnt (
      .clk   (clk),
      .rst   (cnt_rst),
      .inc   (1'b1),
      .value (x_cur),
      .wrap  (h_wrap)
   );

   wrap_counter #(.W(COORD_W), .TC(V_TOT - 1)) u_vcnt (
      .clk   (clk),
      .rst   (cnt_rst),
      .inc   (h_wrap),
      .value (y_cur),
      .wrap  (v_wrap)
   );

   // Coordinates the counters will hold after this edge; flags are built from these to stay aligned
   logic [COORD_W-1:0] x_nxt;
   logic [COORD_W-1:0] y_nxt;
   always_comb begin
      x_nxt = h_wrap ? '0 : x_cur + COORD_W'(1);
      y_nxt = y_cur;
      if (v_wrap) begin
         y_nxt = '0;
      end else if (h_wrap) begin
         y_nxt = y_cur + COORD_W'(1);
      end
   end

   logic draw_q;
   logic line_q;
   logic frame_q;
   logic hs_q;
   logic vs_q;

   // Registered flags describing (x_nxt, y_nxt), which become xpos/ypos on the same edge
   always_ff @(posedge clk) begin
      if (cnt_rst) begin
         draw_q  <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         hs_q    <= ~SYNC_ACTIVE;
         vs_q    <= ~SYNC_ACTIVE;
      end else begin
         draw_q  <= (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
         line_q  <= (x_nxt == '0);
         frame_q <= (x_nxt == '0) && (y_nxt == '0);
         hs_q    <= sync_level((x_nxt >= HS_BEG_C) && (x_nxt < HS_END_C), SYNC_ACTIVE);
         vs_q    <= sync_level((y_nxt >= VS_BEG_C) && (y_nxt < VS_END_C), SYNC_ACTIVE);
      end
   end

`ifdef VGA_TIMING_SYNC_DELAY_EN
   logic hs_d1, hs_d2;
   logic vs_d1, vs_d2;

   // Two extra stages so the syncs line up with a 2-cycle pipelined drawer's pixel output
   always_ff @(posedge clk) begin
      if (cnt_rst) begin
         hs_d1 <= ~SYNC_ACTIVE;
         hs_d2 <= ~SYNC_ACTIVE;
         vs_d1 <= ~SYNC_ACTIVE;
         vs_d2 <= ~SYNC_ACTIVE;
      end else begin
         hs_d1 <= hs_q;
         hs_d2 <= hs_d1;
         vs_d1 <= vs_q;
         vs_d2 <= vs_d1;
      end
   end

   assign vid.hsync = hs_d2;
   assign vid.vsync = vs_d2;
`else
   assign vid.hsync = hs_q;
   assign vid.vsync = vs_q;
`endif

   assign vid.xpos        = x_cur;
   assign vid.ypos        = y_cur;
   assign vid.draw_area   = draw_q;
   assign vid.line_start  = line_q;
   assign vid.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: 640-pixel lines, vertical shrunk to 13 lines to keep runs short.
// Stimulus pushes the expected raster per cycle; a monitor pops and compares every cycle.
// Run-length, period and sync-position checks use hand-computed constants.
module tb_vga_timing_gen;

   // Vertical timing reduced (6 active, 2 fp, 2 sync, 3 bp = 13 lines) so full frames fit the run
   localparam int TV_ACT   = 6;
   localparam int TV_FP    = 2;
   localparam int TV_SYNC  = 2;
   localparam int TV_BP    = 3;
   localparam int TV_TOT   = 13;
   localparam int FRAME_CY = 10400;   // 800 * 13

`ifdef VGA_TIMING_SYNC_DELAY_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       da;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
   } obs_t;

   typedef struct packed {
      obs_t o;
      logic rs;
   } sb_ent_t;

   logic clk;
   logic rst;
   logic pll_lock;

   vga_timing_gen_if vid();

   vga_timing_gen #(
      .V_ACTIVE (TV_ACT),
      .V_FP     (TV_FP),
      .V_SYNC   (TV_SYNC),
      .V_BP     (TV_BP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pll_lock (pll_lock),
      .vid      (vid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int chk = 0;
   int err = 0;
   sb_ent_t sb_q[$];

   // Reference raster state
   int   mx, my, fr_cnt;
   logic hs_raw, hs_d1, hs_d2, vs_raw, vs_d1, vs_d2;

   task automatic check(input string name, input int act, input int exp_v);
      chk++;
      if (act != exp_v) begin
         err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic step(input logic r, input logic l);
      sb_ent_t e;
      @(negedge clk);
      rst      = r;
      pll_lock = l;
      if (r || !l) begin
         mx = 799; my = TV_TOT - 1;
         hs_raw = 1'b1; hs_d1 = 1'b1; hs_d2 = 1'b1;
         vs_raw = 1'b1; vs_d1 = 1'b1; vs_d2 = 1'b1;
         e.rs = 1'b1;
      end else begin
         if (mx == 799) begin
            mx = 0;
            my = (my == TV_TOT - 1) ? 0 : my + 1;
         end else begin
            mx = mx + 1;
         end
         hs_d2 = hs_d1; hs_d1 = hs_raw;
         vs_d2 = vs_d1; vs_d1 = vs_raw;
         hs_raw = (mx >= 656 && mx < 752) ? 1'b0 : 1'b1;
         vs_raw = (my >= 8 && my < 10) ? 1'b0 : 1'b1;
         if (mx == 0 && my == 0) fr_cnt++;
         e.rs = 1'b0;
      end
      e.o.x  = 10'(mx);
      e.o.y  = 10'(my);
      e.o.da = !e.rs && (mx < 640) && (my < TV_ACT);
      e.o.ls = !e.rs && (mx == 0);
      e.o.fs = !e.rs && (mx == 0) && (my == 0);
`ifdef VGA_TIMING_SYNC_DELAY_EN
      e.o.hs = hs_d2;
      e.o.vs = vs_d2;
`else
      e.o.hs = hs_raw;
      e.o.vs = vs_raw;
`endif
      sb_q.push_back(e);
   endtask

   // Monitor: pops one expectation per cycle and measures run lengths / periods
   int cyc = 0;
   int hs_run = 0, hs_x0 = 0;
   int da_run = 0;
   int vs_run = 0, vs_x0 = 0, vs_y0 = 0;
   int last_fs = -1, last_ls = -1;

   always @(posedge clk) begin
      sb_ent_t e;
      obs_t    got;
      #1;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         got = {vid.xpos, vid.ypos, vid.draw_area, vid.hsync, vid.vsync,
                vid.line_start, vid.frame_start};
         cyc++;
         chk++;
         if (got !== e.o) begin
            err++;
            $display("FAIL raster cyc=%0d got x=%0d y=%0d da=%b hs=%b vs=%b ls=%b fs=%b exp x=%0d y=%0d da=%b hs=%b vs=%b ls=%b fs=%b",
                     cyc, got.x, got.y, got.da, got.hs, got.vs, got.ls, got.fs,
                     e.o.x, e.o.y, e.o.da, e.o.hs, e.o.vs, e.o.ls, e.o.fs);
         end
         if (e.rs) begin
            hs_run = 0; da_run = 0; vs_run = 0; last_fs = -1; last_ls = -1;
         end else begin
            if (got.hs == 1'b0) begin
               if (hs_run == 0) hs_x0 = int'(got.x);
               hs_run++;
            end else if (hs_run > 0) begin
               check("hsync_width", hs_run, 96);
               check("hsync_start_x", hs_x0, 656 + SD);
               hs_run = 0;
            end
            if (got.da) begin
               da_run++;
            end else if (da_run > 0) begin
               check("draw_width", da_run, 640);
               da_run = 0;
            end
            if (got.vs == 1'b0) begin
               if (vs_run == 0) begin
                  vs_x0 = int'(got.x);
                  vs_y0 = int'(got.y);
               end
               vs_run++;
            end else if (vs_run > 0) begin
               check("vsync_width", vs_run, 1600);
               check("vsync_start_y", vs_y0, 8);
               check("vsync_start_x", vs_x0, SD);
               vs_run = 0;
            end
            if (got.ls) begin
               if (last_ls >= 0) check("line_period", cyc - last_ls, 800);
               last_ls = cyc;
            end
            if (got.fs) begin
               if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME_CY);
               last_fs = cyc;
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      pll_lock = 1'b1;
      mx = 799; my = TV_TOT - 1; fr_cnt = 0;
      hs_raw = 1'b1; hs_d1 = 1'b1; hs_d2 = 1'b1;
      vs_raw = 1'b1; vs_d1 = 1'b1; vs_d2 = 1'b1;

      // Reset held for 5 cycles
      repeat (5) step(1'b1, 1'b1);

      // Release and run two full frames, up to (300, 3) of the third
      n = 0;
      step(1'b0, 1'b1);
      while (!(fr_cnt == 3 && mx == 300 && my == 3) && n < 30000) begin
         step(1'b0, 1'b1);
         n++;
      end
      check("reached_lock_drop_point", int'(n < 30000), 1);

      // Lock loss for 3 cycles, then relock and run past a full line
      repeat (3) step(1'b0, 1'b0);
      repeat (900) step(1'b0, 1'b1);

      // rst and pll_lock low together, then plain rst, then restart
      repeat (2) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (1700) step(1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule
